// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and frame field widths.
package loader_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian 4-byte word assembler; presents a completed word with a one-cycle word_valid.
module imem_word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [1:0]        byte_idx,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  // Bytes 0..2 of the word in progress; byte 0 ends up in the low lane.
  logic [3*BYTE_W-1:0] lower;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      lower      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        lower    <= '0;
      end else if (byte_valid) begin
        byte_idx <= byte_idx + 2'd1;
        lower    <= {byte_in, lower[3*BYTE_W-1:BYTE_W]};
        if (byte_idx == 2'd3) begin
          word       <= {byte_in, lower};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: framed byte stream in, sequential word writes out,
// core held in reset until a checksummed image has loaded completely.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] IMwaddress,
  output logic [31:0] IMwdata,
  output logic        IMwenable,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  state_t state, state_next;

  logic [BYTE_W-1:0] len_lo;
  logic [LEN_W-1:0]  len;
  logic [BYTE_W-1:0] checksum;
  logic              xfer;
  logic [LEN_W-1:0]  len_rx;
  logic [1:0]        byte_idx;
  logic              last_byte;
  logic              packer_clear;
  logic              packer_byte;

  assign xfer         = rx_valid && rx_ready;
  assign len_rx       = {rx_data, len_lo};
  assign packer_clear = (state == ST_LEN1) && xfer;
  assign packer_byte  = (state == ST_DATA) && xfer;
  assign last_byte    = packer_byte && (byte_idx == 2'd3);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (packer_clear),
    .byte_valid (packer_byte),
    .byte_in    (rx_data),
    .byte_idx   (byte_idx),
    .word       (IMwdata),
    .word_valid (IMwenable)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN0;
      ST_LEN0: if (xfer) state_next = ST_LEN1;
      ST_LEN1: begin
        if (xfer) begin
          if (32'(len_rx) > MAX_WORDS) state_next = ST_ERR;
          else if (len_rx == '0)      state_next = ST_CHK;
          else                        state_next = ST_DATA;
        end
      end
      // Leave DATA on the byte completing word N; the write itself happens in the next cycle.
      ST_DATA: if (last_byte && (words_loaded + 16'd1 == len)) state_next = ST_CHK;
      ST_CHK: begin
        if (xfer) state_next = (rx_data == checksum) ? ST_DONE : ST_ERR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      ST_LEN0, ST_LEN1, ST_DATA, ST_CHK: rx_ready = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo       <= '0;
      len          <= '0;
      checksum     <= '0;
      words_loaded <= '0;
      IMwaddress   <= '0;
    end else begin
      if ((state == ST_LEN0) && xfer) len_lo <= rx_data;
      if (packer_clear) begin
        len          <= len_rx;
        checksum     <= '0;
        words_loaded <= '0;
      end
      if (packer_byte) checksum <= checksum ^ rx_data;
      if (last_byte) begin
        IMwaddress   <= BASE_ADDR + 32'({words_loaded, 2'b00});
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-count frame model checked every cycle, plus directed frames
// with literal expectations and a batch of randomized frames.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] IMwaddress;
  logic [31:0] IMwdata;
  logic        IMwenable;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .IMwaddress   (IMwaddress),
    .IMwdata      (IMwdata),
    .IMwenable    (IMwenable),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: tracks position in the frame by bytes accepted, not by loader state.
  bit          m_acc = 0;
  int          m_cnt = 0;
  int          m_n = 0;
  logic [7:0]  m_lo = '0;
  logic [7:0]  m_x = '0;
  logic [31:0] m_w = '0;
  bit          m_done = 0;
  bit          m_err = 0;
  bit          m_wen = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_wl = 0;
  logic [7:0]  m_b;
  int          m_k;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_acc = 0; m_cnt = 0; m_n = 0; m_lo = '0; m_x = '0; m_w = '0;
      m_done = 0; m_err = 0; m_wen = 0; m_addr = '0; m_data = '0; m_wl = 0;
    end else begin
      m_wen = 0;
      if (!m_acc) begin
        if (start) begin
          m_acc = 1; m_cnt = 0; m_done = 0; m_err = 0;
        end
      end else if (rx_valid) begin
        m_b = rx_data;
        if (m_cnt == 0) m_lo = m_b;
        else if (m_cnt == 1) begin
          m_n = int'({m_b, m_lo});
          m_wl = 0;
          m_x = '0;
          if (m_n > MAXW) begin
            m_acc = 0;
            m_err = 1;
          end
        end else if (m_cnt < 2 + 4 * m_n) begin
          m_k = (m_cnt - 2) % 4;
          m_w[8*m_k +: 8] = m_b;
          m_x = m_x ^ m_b;
          if (m_k == 3) begin
            m_wen = 1;
            m_addr = BASE + 32'(4 * m_wl);
            m_data = m_w;
            m_wl++;
          end
        end else begin
          m_acc = 0;
          if (m_b == m_x) m_done = 1;
          else m_err = 1;
        end
        m_cnt++;
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t log_q[$];

  always @(negedge clk) begin
    check("rx_ready", 32'(rx_ready), 32'(m_acc));
    check("IMwenable", 32'(IMwenable), 32'(m_wen));
    check("done", 32'(done), 32'(m_done));
    check("error", 32'(error), 32'(m_err));
    check("cpu_hold", 32'(cpu_hold), 32'(!m_done));
    check("words_loaded", 32'(words_loaded), 32'(m_wl));
    if (m_wen) begin
      check("IMwaddress", IMwaddress, m_addr);
      check("IMwdata", IMwdata, m_data);
    end
    if (IMwenable === 1'b1) log_q.push_back('{IMwaddress, IMwdata});
  end

  logic [7:0] frame_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!acc && tries < 200) begin
      start = inj && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      acc = rx_ready;
      tick();
      start = 1'b0;
      tries++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL byte_timeout: byte 0x%02h not accepted within 200 cycles", b);
    end
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic send_frame(input int gap_max, input bit inj);
    int n;
    n = int'({frame_q[1], frame_q[0]});
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i >= 2 && n > MAXW) break;
      send_byte(frame_q[i], $urandom_range(0, gap_max), inj);
    end
    rx_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    x = '0;
    if (n <= MAXW) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        x = x ^ b;
      end
    end
    frame_q.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held
    repeat (3) tick();
    check("rst cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst rx_ready", 32'(rx_ready), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst IMwenable", 32'(IMwenable), 32'd0);
    check("rst IMwaddress", IMwaddress, 32'd0);
    check("rst IMwdata", IMwdata, 32'd0);
    check("rst words_loaded", 32'(words_loaded), 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    check("idle writes", 32'(log_q.size()), 32'd0);
    check("idle cpu_hold", 32'(cpu_hold), 32'd1);
    check("idle rx_ready", 32'(rx_ready), 32'd0);

    // Two-word frame; XOR of the eight data bytes is 0x90
    log_q.delete();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00, 8'h90};
    pulse_start();
    send_frame(2, 0);
    check("f1 nwrites", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("f1 addr0", log_q[0].a, 32'h0);
      check("f1 data0", log_q[0].d, 32'h00A00513);
      check("f1 addr1", log_q[1].a, 32'h4);
      check("f1 data1", log_q[1].d, 32'h00B00593);
    end
    check("f1 words_loaded", 32'(words_loaded), 32'd2);
    check("f1 done", 32'(done), 32'd1);
    check("f1 cpu_hold", 32'(cpu_hold), 32'd0);

    // Same frame, wrong checksum bytes
    foreach (frame_q[i]) if (i == 10) frame_q[i] = 8'h18;
    for (int pass = 0; pass < 2; pass++) begin
      log_q.delete();
      pulse_start();
      send_frame(1, 0);
      check("badchk nwrites", 32'(log_q.size()), 32'd2);
      check("badchk error", 32'(error), 32'd1);
      check("badchk done", 32'(done), 32'd0);
      check("badchk cpu_hold", 32'(cpu_hold), 32'd1);
      foreach (frame_q[i]) if (i == 10) frame_q[i] = 8'h19;
    end

    // Oversize length 257
    log_q.delete();
    frame_q = '{8'h01, 8'h01};
    pulse_start();
    send_frame(0, 0);
    check("big error", 32'(error), 32'd1);
    check("big nwrites", 32'(log_q.size()), 32'd0);
    check("big rx_ready", 32'(rx_ready), 32'd0);

    // Zero-gap three-word frame
    log_q.delete();
    build_frame(3, 0);
    pulse_start();
    send_frame(0, 0);
    check("zg nwrites", 32'(log_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < log_q.size(); i++)
      check("zg addr", log_q[i].a, 32'(4 * i));
    check("zg done", 32'(done), 32'd1);

    // Reset mid-DATA after five bytes, then a fresh one-word frame
    build_frame(2, 0);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(frame_q[i], 0, 0);
    #2 reset = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("midrst cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst rx_ready", 32'(rx_ready), 32'd0);
    check("midrst words_loaded", 32'(words_loaded), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    log_q.delete();
    build_frame(1, 0);
    pulse_start();
    send_frame(1, 0);
    check("midrst nwrites", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) check("midrst addr", log_q[0].a, BASE);
    check("midrst words_loaded1", 32'(words_loaded), 32'd1);
    check("midrst done", 32'(done), 32'd1);

    // Boundaries: empty image and a full-depth image
    build_frame(0, 0);
    pulse_start();
    send_frame(0, 0);
    check("empty done", 32'(done), 32'd1);
    log_q.delete();
    build_frame(MAXW, 0);
    pulse_start();
    send_frame(0, 1);
    check("full done", 32'(done), 32'd1);
    check("full words_loaded", 32'(words_loaded), 32'(MAXW));
    if (log_q.size() == MAXW) check("full last addr", log_q[MAXW-1].a, 32'h3FC);
    else check("full nwrites", 32'(log_q.size()), 32'(MAXW));

    // Randomized frames with gaps, stray start pulses and corrupted checksums
    for (int f = 0; f < 25; f++) begin
      int n;
      bit corrupt;
      bit ok;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXW + 1, MAXW + 40) : $urandom_range(0, 6);
      corrupt = ($urandom_range(0, 3) == 0);
      ok = (n <= MAXW) && !corrupt;
      log_q.delete();
      build_frame(n, corrupt);
      pulse_start();
      send_frame($urandom_range(0, 3), 1);
      check("rnd done", 32'(done), 32'(ok));
      check("rnd error", 32'(error), 32'(!ok));
      check("rnd nwrites", 32'(log_q.size()), 32'((n <= MAXW) ? n : 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
